sram_mem_stage: RTL and testbench

Parametrised successor to the pipeline memory stage. It maps the ALU address into a word address in off-chip SRAM. A DATA_W-bit load or store is split into BEATS = DATA_W/SRAM_DQ_W sequential SRAM beats, with programmable wait states per beat. The pipeline is frozen until the transfer completes, and write-back enable is gated by the freeze. It sits between the EXE/MEM and MEM/WB pipeline registers and owns the SRAM pins.

---
 rtl/sram_mem_pkg.sv | 20 ++
 rtl/sram_addr_map.sv | 20 ++
 rtl/sram_mem_stage.sv | 172 +++++++++++++++++
 tb/tb_sram_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_pkg.sv
// Shared types and address helpers for the SRAM-backed pipeline memory stage.
package sram_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} sram_state_e;

  function automatic int beats_of(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Byte offset from the SRAM base to the SRAM location holding beat 0 of that word.
  function automatic logic [63:0] beat0_addr(input logic [63:0] byte_off,
                                             input int data_w, input int dq_w);
    return (byte_off >> $clog2(data_w / 8)) << $clog2(data_w / dq_w);
  endfunction

endpackage

// File: rtl/sram_addr_map.sv
// Maps a pipeline byte address to the SRAM location of beat 0 (modulo wrap, low bits ignored).
module sram_addr_map
  import sram_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int BASE_ADDR   = 1024
) (
  input  logic [ADDR_W-1:0]      i_alu_result,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr
);

  logic [ADDR_W-1:0] w_off;

  assign w_off       = i_alu_result - ADDR_W'(BASE_ADDR);
  assign o_sram_addr = SRAM_ADDR_W'(beat0_addr(64'(w_off), DATA_W, SRAM_DQ_W));

endmodule

// File: rtl/sram_mem_stage.sv
// Pipeline memory stage splitting each word access into SRAM beats with wait states.
// Optional posted write buffer: define SRAM_WRITE_BUFFER_EN.
module sram_mem_stage
  import sram_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [ADDR_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      st_value,
  input  logic                   wb_en,
  output logic [DATA_W-1:0]      memory_result,
  output logic                   mem_wb_en_out,
  output logic                   sram_freeze,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int BEATS  = beats_of(DATA_W, SRAM_DQ_W);
  localparam int BEAT_W = beat_idx_w(BEATS);
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);

  sram_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [BEAT_W-1:0]      r_beat;
  logic                   r_is_wr;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      r_rd_buf;
  logic [DATA_W-1:0]      r_mem_result;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;

  logic                   w_req;
  logic                   w_start;
  logic                   w_freeze_raw;
  logic                   w_access;
  logic [SRAM_ADDR_W-1:0] w_map_addr;
  logic [SRAM_DQ_W-1:0]   w_wr_beat;
  logic [DATA_W-1:0]      w_rd_next;

  sram_addr_map #(
    .ADDR_W      (ADDR_W),
    .SRAM_ADDR_W (SRAM_ADDR_W),
    .DATA_W      (DATA_W),
    .SRAM_DQ_W   (SRAM_DQ_W),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr_map (
    .i_alu_result (alu_result),
    .o_sram_addr  (w_map_addr)
  );

  // Handshake: a request (mem_r_en/mem_w_en) is accepted on the edge where the stage
  // can start; sram_freeze high means "not done yet" and the pipeline must hold the
  // request and all other inputs steady until freeze drops.
  assign w_req    = mem_r_en | mem_w_en;
  assign w_access = (r_state == ACCESS);

`ifdef SRAM_WRITE_BUFFER_EN
  logic r_posted;

  // A draining posted store hands over directly to a waiting request in its DONE cycle.
  assign w_start = w_req & ((r_state == IDLE) | ((r_state == DONE) & r_posted));

  always_comb begin
    w_freeze_raw = 1'b0;
    case (r_state)
      IDLE:    w_freeze_raw = mem_r_en & ~mem_w_en;
      ACCESS:  w_freeze_raw = r_posted ? w_req : 1'b1;
      DONE:    w_freeze_raw = r_posted & mem_r_en & ~mem_w_en;
      default: w_freeze_raw = 1'b0;
    endcase
  end
`else
  assign w_start = w_req & (r_state == IDLE);

  always_comb begin
    w_freeze_raw = 1'b0;
    case (r_state)
      IDLE:    w_freeze_raw = w_req;
      ACCESS:  w_freeze_raw = 1'b1;
      default: w_freeze_raw = 1'b0;
    endcase
  end
`endif

  always_comb begin
    w_wr_beat = '0;
    w_rd_next = r_rd_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat == BEAT_W'(k)) begin
        w_wr_beat = r_data[k*SRAM_DQ_W +: SRAM_DQ_W];
        w_rd_next[k*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_beat       <= '0;
      r_is_wr      <= 1'b0;
      r_data       <= '0;
      r_rd_buf     <= '0;
      r_mem_result <= '0;
      r_sram_addr  <= '0;
`ifdef SRAM_WRITE_BUFFER_EN
      r_posted     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state     <= ACCESS;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_is_wr     <= mem_w_en;
            r_data      <= st_value;
            r_sram_addr <= w_map_addr;
`ifdef SRAM_WRITE_BUFFER_EN
            r_posted    <= mem_w_en;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_W'(WAIT_CYCLES)) begin
            r_cnt <= '0;
            if (!r_is_wr) r_rd_buf <= w_rd_next;
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              r_state <= DONE;
              if (!r_is_wr) r_mem_result <= w_rd_next;
            end else begin
              r_beat      <= r_beat + 1'b1;
              r_sram_addr <= r_sram_addr + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_freeze   = reset & w_freeze_raw;
  assign mem_wb_en_out = reset & wb_en & ~w_freeze_raw;
  assign memory_result = r_mem_result;

  // WE_N stays high in each beat's setup cycle so address settles before the strobe.
  assign SRAM_CE_N = ~w_access;
  assign SRAM_UB_N = ~w_access;
  assign SRAM_LB_N = ~w_access;
  assign SRAM_WE_N = ~(w_access & r_is_wr & (r_cnt != '0));
  assign SRAM_OE_N = ~(w_access & ~r_is_wr);
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_DQ   = (w_access & r_is_wr) ? w_wr_beat : 'z;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage: default 32-bit instance plus a 64-bit, 2-wait instance.
`timescale 1ns/1ps
module tb_sram_mem_stage;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        a_r_en, a_w_en, a_wb;
  logic [31:0] a_alu, a_st;
  wire  [31:0] a_mem_res;
  wire         a_wb_out, a_freeze, a_ub_n, a_lb_n, a_we_n, a_ce_n, a_oe_n;
  wire  [15:0] a_dq;
  wire  [17:0] a_addr;

  logic        b_r_en, b_w_en, b_wb;
  logic [31:0] b_alu;
  logic [63:0] b_st;
  wire  [63:0] b_mem_res;
  wire         b_wb_out, b_freeze, b_ub_n, b_lb_n, b_we_n, b_ce_n, b_oe_n;
  wire  [15:0] b_dq;
  wire  [17:0] b_addr;

  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  int errors = 0;
  int checks = 0;

  sram_mem_stage u_dut_a (
    .clock(clock), .reset(reset), .mem_r_en(a_r_en), .mem_w_en(a_w_en),
    .alu_result(a_alu), .st_value(a_st), .wb_en(a_wb), .memory_result(a_mem_res),
    .mem_wb_en_out(a_wb_out), .sram_freeze(a_freeze), .SRAM_DQ(a_dq), .SRAM_ADDR(a_addr),
    .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n), .SRAM_WE_N(a_we_n), .SRAM_CE_N(a_ce_n),
    .SRAM_OE_N(a_oe_n)
  );

  sram_mem_stage #(.DATA_W(64), .WAIT_CYCLES(2)) u_dut_b (
    .clock(clock), .reset(reset), .mem_r_en(b_r_en), .mem_w_en(b_w_en),
    .alu_result(b_alu), .st_value(b_st), .wb_en(b_wb), .memory_result(b_mem_res),
    .mem_wb_en_out(b_wb_out), .sram_freeze(b_freeze), .SRAM_DQ(b_dq), .SRAM_ADDR(b_addr),
    .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n), .SRAM_WE_N(b_we_n), .SRAM_CE_N(b_ce_n),
    .SRAM_OE_N(b_oe_n)
  );

  // Asynchronous SRAM models: read drives while OE_N/CE_N low, write captures while WE_N low.
  assign a_dq = (!a_ce_n && !a_oe_n) ? mem_a[a_addr] : 16'bz;
  assign b_dq = (!b_ce_n && !b_oe_n) ? mem_b[b_addr] : 16'bz;
  always @(posedge clock) if (!a_ce_n && !a_we_n) mem_a[a_addr] <= a_dq;
  always @(posedge clock) if (!b_ce_n && !b_we_n) mem_b[b_addr] <= b_dq;

  // Driver: present one request, count frozen cycles, and capture results at release.
  task automatic run_a(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic wb,
                       output int frz, output int we_lo, output int wb_bad,
                       output logic wb_done, output logic [31:0] res_first,
                       output logic [31:0] res_done);
    @(negedge clock);
    a_r_en = rd; a_w_en = wr; a_alu = addr; a_st = data; a_wb = wb;
    #1;
    frz = 0; we_lo = 0; wb_bad = 0;
    res_first = a_mem_res;
    while (a_freeze === 1'b1 && frz < 40) begin
      frz++;
      if (a_we_n === 1'b0) we_lo++;
      if (a_wb_out !== 1'b0) wb_bad++;
      @(negedge clock); #1;
    end
    wb_done  = a_wb_out;
    res_done = a_mem_res;
    if (frz == 0) begin
      @(posedge clock); #1;
    end
    a_r_en = 1'b0; a_w_en = 1'b0; a_wb = 1'b0;
  endtask

  task automatic run_b(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] data, output int frz, output logic wb_done,
                       output logic [63:0] res_done);
    @(negedge clock);
    b_r_en = rd; b_w_en = wr; b_alu = addr; b_st = data; b_wb = 1'b1;
    #1;
    frz = 0;
    while (b_freeze === 1'b1 && frz < 60) begin
      frz++;
      @(negedge clock); #1;
    end
    wb_done  = b_wb_out;
    res_done = b_mem_res;
    b_r_en = 1'b0; b_w_en = 1'b0; b_wb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    a_w_en = 1'b1; a_wb = 1'b1; b_w_en = 1'b1; b_wb = 1'b1;
    @(negedge clock); #1;
    checks++; if (a_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b want 0", a_freeze); end
    checks++; if (a_wb_out !== 1'b0) begin errors++; $display("FAIL reset_wb: got %b want 0", a_wb_out); end
    checks++; if ({a_we_n, a_ce_n, a_oe_n, a_ub_n, a_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_ctl_a: got %b want 11111", {a_we_n, a_ce_n, a_oe_n, a_ub_n, a_lb_n}); end
    checks++; if ({b_we_n, b_ce_n, b_oe_n, b_ub_n, b_lb_n, b_freeze, b_wb_out} !== 7'b1111100) begin
      errors++; $display("FAIL reset_ctl_b: got %b want 1111100", {b_we_n, b_ce_n, b_oe_n, b_ub_n, b_lb_n, b_freeze, b_wb_out}); end
    checks++; if (a_mem_res !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", a_mem_res); end
    a_w_en = 1'b0; a_wb = 1'b0; b_w_en = 1'b0; b_wb = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_store();
    int frz, we_lo, wb_bad; logic wb_done; logic [31:0] r0, r1;
    run_a(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 5) begin errors++; $display("FAIL store_freeze: got %0d want 5", frz); end
    checks++; if (we_lo != 2) begin errors++; $display("FAIL store_we_low: got %0d want 2", we_lo); end
    checks++; if (wb_bad != 0) begin errors++; $display("FAIL store_wb_frozen: got %0d want 0", wb_bad); end
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL store_wb_done: got %b want 1", wb_done); end
    checks++; if (mem_a[2] !== 16'hBEEF) begin errors++; $display("FAIL store_beat0: got %h want beef", mem_a[2]); end
    checks++; if (mem_a[3] !== 16'hDEAD) begin errors++; $display("FAIL store_beat1: got %h want dead", mem_a[3]); end
  endtask

  task automatic test_load();
    int frz, we_lo, wb_bad; logic wb_done; logic [31:0] r0, r1;
    run_a(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 5) begin errors++; $display("FAIL load_freeze: got %0d want 5", frz); end
    checks++; if (wb_bad != 0) begin errors++; $display("FAIL load_wb_frozen: got %0d want 0", wb_bad); end
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL load_wb_done: got %b want 1", wb_done); end
    checks++; if (r0 !== 32'h0) begin errors++; $display("FAIL load_result_early: got %h want 0", r0); end
    checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_result: got %h want deadbeef", r1); end
  endtask

  task automatic test_both_requests();
    int frz, we_lo, wb_bad; logic wb_done; logic [31:0] r0, r1;
    run_a(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 5) begin errors++; $display("FAIL both_freeze: got %0d want 5", frz); end
    checks++; if (we_lo != 2) begin errors++; $display("FAIL both_we_low: got %0d want 2", we_lo); end
    checks++; if (mem_a[4] !== 16'hA5A5) begin errors++; $display("FAIL both_beat0: got %h want a5a5", mem_a[4]); end
    checks++; if (mem_a[5] !== 16'h0000) begin errors++; $display("FAIL both_beat1: got %h want 0000", mem_a[5]); end
    checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL both_result_held: got %h want deadbeef", r1); end
  endtask

  task automatic test_reset_mid_write();
    int frz, we_lo, wb_bad; logic wb_done; logic [31:0] r0, r1;
    @(negedge clock);
    a_w_en = 1'b1; a_alu = 32'd1036; a_st = 32'h12345678; a_wb = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    checks++; if ({a_we_n, a_ce_n, a_ub_n} !== 3'b000) begin
      errors++; $display("FAIL mid_active_ctl: got %b want 000", {a_we_n, a_ce_n, a_ub_n}); end
    checks++; if (a_addr !== 18'd7) begin errors++; $display("FAIL mid_beat1_addr: got %0d want 7", a_addr); end
    reset = 1'b0;
    #1;
    checks++; if ({a_we_n, a_ce_n, a_oe_n, a_lb_n} !== 4'b1111) begin
      errors++; $display("FAIL mid_reset_ctl: got %b want 1111", {a_we_n, a_ce_n, a_oe_n, a_lb_n}); end
    checks++; if (a_freeze !== 1'b0) begin errors++; $display("FAIL mid_reset_freeze: got %b want 0", a_freeze); end
    checks++; if (a_wb_out !== 1'b0) begin errors++; $display("FAIL mid_reset_wb: got %b want 0", a_wb_out); end
    checks++; if (a_mem_res !== 32'h0) begin errors++; $display("FAIL mid_reset_result: got %h want 0", a_mem_res); end
    a_w_en = 1'b0; a_wb = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_a(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 5) begin errors++; $display("FAIL post_reset_freeze: got %0d want 5", frz); end
    checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL post_reset_load: got %h want deadbeef", r1); end
  endtask

  task automatic test_wide();
    int frz; logic wb_done; logic [63:0] res;
    run_b(1'b0, 1'b1, 32'd1032, 64'h1122334455667788, frz, wb_done, res);
    checks++; if (frz != 13) begin errors++; $display("FAIL wide_store_freeze: got %0d want 13", frz); end
    checks++; if ({mem_b[7], mem_b[6], mem_b[5], mem_b[4]} !== 64'h1122334455667788) begin
      errors++; $display("FAIL wide_store_beats: got %h want 1122334455667788", {mem_b[7], mem_b[6], mem_b[5], mem_b[4]}); end
    run_b(1'b1, 1'b0, 32'd1032, 64'h0, frz, wb_done, res);
    checks++; if (frz != 13) begin errors++; $display("FAIL wide_load_freeze: got %0d want 13", frz); end
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL wide_load_wb: got %b want 1", wb_done); end
    checks++; if (res !== 64'h1122334455667788) begin errors++; $display("FAIL wide_load_result: got %h want 1122334455667788", res); end
  endtask

  task automatic test_write_buffer();
    int frz, we_lo, wb_bad; logic wb_done; logic [31:0] r0, r1;
    run_a(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 0) begin errors++; $display("FAIL wbuf_store_freeze: got %0d want 0", frz); end
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL wbuf_store_wb: got %b want 1", wb_done); end
    run_a(1'b1, 1'b0, 32'd1040, 32'h0, 1'b1, frz, we_lo, wb_bad, wb_done, r0, r1);
    checks++; if (frz != 9) begin errors++; $display("FAIL wbuf_load_freeze: got %0d want 9", frz); end
    checks++; if (wb_bad != 0) begin errors++; $display("FAIL wbuf_load_wb_frozen: got %0d want 0", wb_bad); end
    checks++; if (r1 !== 32'hCAFEF00D) begin errors++; $display("FAIL wbuf_load_result: got %h want cafef00d", r1); end
    checks++; if ({mem_a[9], mem_a[8]} !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wbuf_sram: got %h want cafef00d", {mem_a[9], mem_a[8]}); end
  endtask

  initial begin
    reset = 1'b1;
    a_r_en = 1'b0; a_w_en = 1'b0; a_wb = 1'b0; a_alu = '0; a_st = '0;
    b_r_en = 1'b0; b_w_en = 1'b0; b_wb = 1'b0; b_alu = '0; b_st = '0;
    test_reset();
`ifdef SRAM_WRITE_BUFFER_EN
    test_write_buffer();
`else
    test_store();
    test_load();
    test_both_requests();
    test_reset_mid_write();
    test_wide();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
